// File: rtl/uart_tx_model.sv
// UART transmitter model: valid/ready byte push into a small circular FIFO,
// serialized as start / LSB-first data / stop frames on uart_txd.
module uart_tx_model #(
   parameter int unsigned BIT_RATE     = 9600,
   parameter int unsigned CLK_HZ       = 50_000_000,
   parameter int unsigned PAYLOAD_BITS = 8,
   parameter int unsigned STOP_BITS    = 1,
   parameter int unsigned FIFO_DEPTH   = 16
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          uart_tx_en,
   input  logic                          in_valid,
   input  logic [7:0]                    in_data,
   output logic                          in_ready,
   output logic                          uart_txd,
   output logic                          uart_tx_busy,
   output logic                          uart_tx_done,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

   localparam int unsigned CYCLES_PER_BIT = CLK_HZ / BIT_RATE;
   localparam int unsigned CNT_W   = (CYCLES_PER_BIT > 1) ? $clog2(CYCLES_PER_BIT) : 1;
   localparam int unsigned STOP_CYC = STOP_BITS * CYCLES_PER_BIT;
   localparam int unsigned STOP_W  = (STOP_CYC > 1) ? $clog2(STOP_CYC) : 1;
   localparam int unsigned IDX_W   = $clog2(PAYLOAD_BITS);
   localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
   localparam int unsigned FCNT_W  = PTR_W + 1;

   localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(CYCLES_PER_BIT - 1);
   localparam logic [STOP_W-1:0] STOP_LAST = STOP_W'(STOP_CYC - 1);
   localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(PAYLOAD_BITS - 1);
   localparam logic [FCNT_W-1:0] FIFO_FULL = FCNT_W'(FIFO_DEPTH);

   typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

   state_e                  state;
   logic [CNT_W-1:0]        bit_cnt;
   logic [STOP_W-1:0]       stop_cnt;
   logic [IDX_W-1:0]        bit_idx;
   logic [PAYLOAD_BITS-1:0] shift;

   logic [PAYLOAD_BITS-1:0] mem [FIFO_DEPTH];
   logic [PTR_W-1:0]        wr_ptr;
   logic [PTR_W-1:0]        rd_ptr;
   logic                    full;
   logic                    push;
   logic                    pop;

   assign full     = (fifo_count == FIFO_FULL);
   assign in_ready = ~full;
   assign push     = in_valid & in_ready;

   // Pop from idle, or on the final stop cycle so the next start bit follows with no gap.
   assign pop = uart_tx_en && (fifo_count != '0) &&
                ((state == StIdle) || ((state == StStop) && (stop_cnt == '0)));

   // FIFO storage; not reset, occupancy is tracked by the pointers and count.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= in_data[PAYLOAD_BITS-1:0];
      end
   end

   // Write pointer and occupancy; simultaneous push and pop leave the count alone.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (push && !pop) begin
            fifo_count <= fifo_count + 1'b1;
         end else if (pop && !push) begin
            fifo_count <= fifo_count - 1'b1;
         end
      end
   end

   // Frame FSM with registered line, busy and done outputs; also owns the read pointer.
   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= StIdle;
         uart_txd     <= 1'b1;
         uart_tx_busy <= 1'b0;
         uart_tx_done <= 1'b0;
         bit_cnt      <= '0;
         stop_cnt     <= '0;
         bit_idx      <= '0;
         shift        <= '0;
         rd_ptr       <= '0;
      end else begin
         uart_tx_done <= 1'b0;
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         unique case (state)
            StIdle: begin
               if (pop) begin
                  shift        <= mem[rd_ptr];
                  uart_txd     <= 1'b0;
                  uart_tx_busy <= 1'b1;
                  bit_cnt      <= '0;
                  state        <= StStart;
               end
            end
            StStart: begin
               if (bit_cnt == BIT_LAST) begin
                  bit_cnt  <= '0;
                  bit_idx  <= '0;
                  uart_txd <= shift[0];
                  state    <= StData;
               end else begin
                  bit_cnt <= bit_cnt + 1'b1;
               end
            end
            StData: begin
               if (bit_cnt == BIT_LAST) begin
                  bit_cnt <= '0;
                  if (bit_idx == IDX_LAST) begin
                     uart_txd     <= 1'b1;
                     stop_cnt     <= STOP_LAST;
                     uart_tx_done <= (STOP_CYC == 1);
                     state        <= StStop;
                  end else begin
                     // Line shows the next bit as it shifts into position 0.
                     shift    <= shift >> 1;
                     uart_txd <= shift[1];
                     bit_idx  <= bit_idx + 1'b1;
                  end
               end else begin
                  bit_cnt <= bit_cnt + 1'b1;
               end
            end
            StStop: begin
               if (stop_cnt == '0) begin
                  if (pop) begin
                     shift    <= mem[rd_ptr];
                     uart_txd <= 1'b0;
                     bit_cnt  <= '0;
                     state    <= StStart;
                  end else begin
                     uart_tx_busy <= 1'b0;
                     state        <= StIdle;
                  end
               end else begin
                  stop_cnt <= stop_cnt - 1'b1;
                  // Done is registered, so raise it while entering the final stop cycle.
                  uart_tx_done <= (stop_cnt == STOP_W'(1));
               end
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_model.sv
// Directed bench for uart_tx_model at 10 cycles/bit: 8N1 main instance plus a
// 7-data/2-stop instance for the alternate frame format.
module tb_uart_tx_model;

   logic       clk = 1'b0;
   logic       reset;
   logic       en;
   logic       in_valid, in_valid2;
   logic [7:0] in_data, in_data2;
   logic       in_ready, txd, busy, done;
   logic       in_ready2, txd2, busy2, done2;
   logic [4:0] fifo_count, fifo_count2;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   uart_tx_model #(
      .BIT_RATE(100_000), .CLK_HZ(1_000_000), .PAYLOAD_BITS(8), .STOP_BITS(1), .FIFO_DEPTH(16)
   ) dut (
      .clk(clk), .reset(reset), .uart_tx_en(en), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .uart_txd(txd), .uart_tx_busy(busy), .uart_tx_done(done),
      .fifo_count(fifo_count)
   );

   uart_tx_model #(
      .BIT_RATE(100_000), .CLK_HZ(1_000_000), .PAYLOAD_BITS(7), .STOP_BITS(2), .FIFO_DEPTH(16)
   ) dut2 (
      .clk(clk), .reset(reset), .uart_tx_en(en), .in_valid(in_valid2), .in_data(in_data2),
      .in_ready(in_ready2), .uart_txd(txd2), .uart_tx_busy(busy2), .uart_tx_done(done2),
      .fifo_count(fifo_count2)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   // Caller is positioned on frame cycle 'first' (1-based); checks through cycle 100.
   // Drops uart_tx_en after cycle 'drop_at' is sampled when drop_at is nonzero.
   task automatic frame_body(input logic [7:0] b, input int first, input int drop_at,
                             output logic [7:0] got);
      int   k;
      logic exp;
      got = 8'h00;
      for (int c = first; c <= 100; c++) begin
         if (c != first) tick();
         k = (c - 1) / 10;
         if (k == 0) exp = 1'b0;
         else if (k <= 8) exp = b[k-1];
         else exp = 1'b1;
         chk($sformatf("txd %02h c%0d", b, c), {31'd0, txd}, {31'd0, exp});
         chk($sformatf("done %02h c%0d", b, c), {31'd0, done}, {31'd0, (c == 100)});
         chk($sformatf("busy %02h c%0d", b, c), {31'd0, busy}, 32'd1);
         if ((c % 10 == 5) && (k >= 1) && (k <= 8)) got[k-1] = txd;
         if (c == drop_at) en = 1'b0;
      end
   endtask

   initial begin
      logic [7:0] g, g0, g1, g2;
      logic [7:0] c4 [4];
      reset = 1'b1; en = 1'b0;
      in_valid = 1'b0; in_data = 8'h00; in_valid2 = 1'b0; in_data2 = 8'h00;
      tick(); tick();
      chk("rst txd", {31'd0, txd}, 32'd1);
      chk("rst busy", {31'd0, busy}, 32'd0);
      chk("rst done", {31'd0, done}, 32'd0);
      chk("rst ready", {31'd0, in_ready}, 32'd1);
      chk("rst count", {27'd0, fifo_count}, 32'd0);
      chk("rst txd2", {31'd0, txd2}, 32'd1);
      reset = 1'b0; en = 1'b1;
      tick();

      // Single 0x55 frame with 2-cycle push-to-start latency.
      in_valid = 1'b1; in_data = 8'h55;
      tick();
      in_valid = 1'b0;
      chk("t1 count", {27'd0, fifo_count}, 32'd1);
      chk("t1 lat1 txd", {31'd0, txd}, 32'd1);
      tick();
      chk("t1 lat2 txd", {31'd0, txd}, 32'd0);
      frame_body(8'h55, 1, 0, g);
      chk("t1 byte", {24'd0, g}, 32'h55);
      tick();
      chk("t1 idle txd", {31'd0, txd}, 32'd1);
      chk("t1 idle busy", {31'd0, busy}, 32'd0);
      chk("t1 idle done", {31'd0, done}, 32'd0);

      // Back-to-back "AB\n".
      in_valid = 1'b1; in_data = 8'h41;
      tick();
      in_data = 8'h42;
      tick();
      chk("t2 start", {31'd0, txd}, 32'd0);
      in_data = 8'h0A;
      tick();
      in_valid = 1'b0;
      chk("t2 count", {27'd0, fifo_count}, 32'd2);
      frame_body(8'h41, 2, 0, g0);
      tick();
      frame_body(8'h42, 1, 0, g1);
      tick();
      frame_body(8'h0A, 1, 0, g2);
      chk("t2 text", {8'd0, g0, g1, g2}, 32'h0041420A);
      tick();
      chk("t2 idle busy", {31'd0, busy}, 32'd0);

      // Fill FIFO while disabled, reject a 17th push, then drain in order.
      en = 1'b0;
      for (int i = 0; i < 16; i++) begin
         in_valid = 1'b1; in_data = 8'h60 + 8'(i);
         tick();
      end
      in_data = 8'hEE;
      chk("t3 full count", {27'd0, fifo_count}, 32'd16);
      chk("t3 full ready", {31'd0, in_ready}, 32'd0);
      tick();
      in_valid = 1'b0;
      chk("t3 reject count", {27'd0, fifo_count}, 32'd16);
      chk("t3 held txd", {31'd0, txd}, 32'd1);
      en = 1'b1;
      tick();
      chk("t3 pop count", {27'd0, fifo_count}, 32'd15);
      for (int i = 0; i < 16; i++) begin
         if (i > 0) tick();
         frame_body(8'h60 + 8'(i), 1, 0, g);
         chk($sformatf("t3 byte%0d", i), {24'd0, g}, 32'h60 + 32'(i));
      end
      chk("t3 empty count", {27'd0, fifo_count}, 32'd0);
      tick();

      // Simultaneous push and pop at count 3, with pointers past the wrap.
      c4[0] = 8'hC1; c4[1] = 8'h3E; c4[2] = 8'h99; c4[3] = 8'h07;
      en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1; in_data = c4[i];
         tick();
      end
      chk("t4 count3", {27'd0, fifo_count}, 32'd3);
      en = 1'b1; in_data = c4[3];
      tick();
      in_valid = 1'b0;
      chk("t4 push+pop", {27'd0, fifo_count}, 32'd3);
      for (int i = 0; i < 4; i++) begin
         if (i > 0) tick();
         frame_body(c4[i], 1, 0, g);
         chk($sformatf("t4 byte%0d", i), {24'd0, g}, {24'd0, c4[i]});
      end
      tick();
      chk("t4 idle busy", {31'd0, busy}, 32'd0);

      // Drop enable mid-DATA: first frame completes, second waits.
      in_valid = 1'b1; in_data = 8'h5A;
      tick();
      in_data = 8'h3C;
      tick();
      in_valid = 1'b0;
      frame_body(8'h5A, 1, 35, g);
      tick();
      chk("t5 stop txd", {31'd0, txd}, 32'd1);
      chk("t5 stop busy", {31'd0, busy}, 32'd0);
      chk("t5 count", {27'd0, fifo_count}, 32'd1);
      repeat (20) tick();
      chk("t5 wait busy", {31'd0, busy}, 32'd0);
      chk("t5 wait count", {27'd0, fifo_count}, 32'd1);
      en = 1'b1;
      tick();
      frame_body(8'h3C, 1, 0, g);
      chk("t5 byte2", {24'd0, g}, 32'h3C);
      tick();

      // Reset at frame cycle 45 with another byte queued.
      in_valid = 1'b1; in_data = 8'hA5;
      tick();
      in_data = 8'h96;
      tick();
      in_valid = 1'b0;
      repeat (44) tick();
      chk("t6 pre txd", {31'd0, txd}, 32'd0);
      chk("t6 pre count", {27'd0, fifo_count}, 32'd1);
      reset = 1'b1;
      tick();
      chk("t6 rst txd", {31'd0, txd}, 32'd1);
      chk("t6 rst count", {27'd0, fifo_count}, 32'd0);
      chk("t6 rst busy", {31'd0, busy}, 32'd0);
      chk("t6 rst done", {31'd0, done}, 32'd0);
      chk("t6 rst ready", {31'd0, in_ready}, 32'd1);
      reset = 1'b0;
      repeat (30) tick();
      chk("t6 flushed txd", {31'd0, txd}, 32'd1);
      chk("t6 flushed busy", {31'd0, busy}, 32'd0);

      // 7 data bits, 2 stop bits: 0x7F gives 10 low cycles then 90 high, 100 total.
      in_valid2 = 1'b1; in_data2 = 8'h7F;
      tick();
      in_valid2 = 1'b0;
      tick();
      for (int c = 1; c <= 100; c++) begin
         if (c > 1) tick();
         chk($sformatf("f72 txd c%0d", c), {31'd0, txd2}, {31'd0, (c > 10)});
         chk($sformatf("f72 done c%0d", c), {31'd0, done2}, {31'd0, (c == 100)});
         chk($sformatf("f72 busy c%0d", c), {31'd0, busy2}, 32'd1);
      end
      tick();
      chk("f72 end busy", {31'd0, busy2}, 32'd0);
      chk("f72 end txd", {31'd0, txd2}, 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/uart_tx_model.md
# uart_tx_model

Testbench UART transmitter for the CEP co-simulation environment. It accepts bytes over a valid/ready push interface, buffers them in a small FIFO, and serializes each byte as a standard asynchronous frame on `uart_txd`. That pin drives the DUT's UART receive pin, so C-side tests can inject console input. It is the transmit-side companion of the bench's UART receiver/logger, and the two share the same frame-format parameters.

## Interface
- `BIT_RATE`, 9600: line rate in bits/s.
- `CLK_HZ`, 50_000_000: `clk` frequency in Hz.
- `PAYLOAD_BITS`, 8: data bits per frame; legal range 5..8.
- `STOP_BITS`, 1: stop bits per frame; legal values 1 or 2.
- `FIFO_DEPTH`, 16: byte FIFO entries; must be a power of 2 and at least 2.

Ports:
- `clk` in 1: single clock; all logic is on its rising edge.
- `reset` in 1: synchronous, active-high reset.
- `uart_tx_en` in 1: permits the start of new frames. A frame already in flight always completes.
- `in_valid` in 1: a push request is present.
- `in_data` in 8: byte to push; only bits `[PAYLOAD_BITS-1:0]` are transmitted.
- `in_ready` out 1: FIFO not full. A push occurs when `in_valid && in_ready`.
- `uart_txd` out 1: serial line; idles high.
- `uart_tx_busy` out 1: high whenever the FSM is not in IDLE.
- `uart_tx_done` out 1: one-cycle pulse on the last cycle of the final stop bit.
- `fifo_count` out `$clog2(FIFO_DEPTH)+1`: number of occupied FIFO entries, 0..`FIFO_DEPTH`.

## Operation
- Bit period: `CYCLES_PER_BIT = CLK_HZ / BIT_RATE`, using integer division with truncation. A counter of width `$clog2(CYCLES_PER_BIT)` counts 0..`CYCLES_PER_BIT-1` for each bit.
- Frame layout: one start bit (0), then `PAYLOAD_BITS` data bits LSB first, then `STOP_BITS` stop bits (1). There is no parity.
- FIFO:
  - Circular buffer with read and write pointers that wrap modulo `FIFO_DEPTH`.
  - Push and pop in the same cycle leave `fifo_count` unchanged.
  - A push while full cannot happen because `in_ready` is 0.
  - A pop while empty never occurs.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: `uart_txd` = 1. If `uart_tx_en` is high and `fifo_count` > 0, pop the head byte into the shift register and go to START.
  - START: `uart_txd` = 0 for `CYCLES_PER_BIT` cycles, then go to DATA with bit index 0.
  - DATA: `uart_txd` = `shift[0]`. At the end of each bit period, shift right and increment the index. After bit `PAYLOAD_BITS-1`, go to STOP.
  - STOP: `uart_txd` = 1 for `STOP_BITS*CYCLES_PER_BIT` cycles. On the last cycle:
    - pulse `uart_tx_done`;
    - if `uart_tx_en` is high and the FIFO is non-empty, pop and go directly to START, with no idle gap;
    - otherwise go to IDLE.
- Deasserting `uart_tx_en` mid-frame: the current frame finishes normally and no further pop occurs. Bytes remain in the FIFO until `uart_tx_en` returns high.
- Reset asserted at any point, including mid-frame:
  - next edge: state = IDLE, `uart_txd` = 1, FIFO flushed, all counters cleared;
  - a truncated frame on the line is acceptable.

## Timing
- Reset values: `uart_txd`=1, `uart_tx_busy`=0, `uart_tx_done`=0, `in_ready`=1, `fifo_count`=0.
- Every output is registered except `in_ready`, which is combinational from the full flag.
- Push in cycle t updates `fifo_count` at t+1.
- From IDLE, with a pop at edge t, `uart_txd` falls at t+1, and `uart_tx_busy` rises at t+1.
- Frame length is exactly `(1+PAYLOAD_BITS+STOP_BITS)*CYCLES_PER_BIT` cycles.
- Back-to-back frames: the next start bit begins on the cycle immediately after the last stop-bit cycle.
- Latency from a push into an empty FIFO while idle to the start-bit falling edge: 2 cycles. The push is seen at t+1, the pop happens at t+1, and the start bit appears at t+2.
- `uart_tx_done` and the STOP-to-START pop occur in the same cycle.

## Test plan
Use `CLK_HZ`=1_000_000 and `BIT_RATE`=100_000, giving 10 cycles/bit. This is 8N1 unless noted.

1. Reset, then push 0x55 with `uart_tx_en`=1 -> `uart_txd` reads 0,1,0,1,0,1,0,1,0,1, each level held 10 cycles. `uart_tx_done` pulses at cycle 100 of the frame, then the line stays high and `uart_tx_busy`=0.
2. Push 0x41, 0x42, 0x0A back-to-back -> three contiguous 100-cycle frames with no idle cycles between them. A bench `uart_rx` loopback logs "AB\n".
3. Hold `uart_tx_en`=0 and push 16 bytes -> `fifo_count`=16 and `in_ready`=0, and a 17th push is rejected. After enabling, all 16 bytes are sent in order and `fifo_count` reaches 0.
4. Push and pop in the same cycle while `fifo_count`=3 -> `fifo_count` stays 3. Pointer wrap after more than 16 total pushes preserves byte order.
5. Deassert `uart_tx_en` during the DATA bits of the first of two frames -> the first frame completes, the second waits, and `fifo_count`=1.
6. Assert `reset` at cycle 45 of a frame -> next edge `uart_txd`=1, `fifo_count`=0, `uart_tx_busy`=0. With `STOP_BITS`=2, `PAYLOAD_BITS`=7, byte 0x7F gives a 100-cycle frame.
